clk_div_prog: RTL
=================

# clk_div_prog

Runtime-programmable integer clock divider that generates a divided clock (`out_clk`) and a single-cycle `tick` strobe from one source clock. It generalises the fixed divide-by-2 flop to any ratio N from 2 to 2^CNT_W−1, with enable gating and ratio changes that never produce a truncated or glitched period. It sits at the clock-generation edge of the design, next to the existing divide-by-2, and feeds slow peripheral domains and rate-enable strobes.

## Interface
- `CNT_W`, 8: width of the ratio input and the internal counter.
- `DIV_RESET`, 2: active ratio after reset; must be ≥2 and ≤2^CNT_W−1.

- `clk`  in  1  source clock; all state is on its rising edge, except the optional negedge stage.
- `rst`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `en`  in  1  run request; sampled at period boundaries and while idle.
- `div_val`  in  CNT_W  requested ratio N; values 0 and 1 are treated as 2.
- `out_clk`  out  1  divided clock.
- `tick`  out  1  one-`clk` pulse coincident with each `out_clk` rising edge.
- `div_act`  out  CNT_W  ratio currently in effect.

## Operation
- Registers: `cnt` (CNT_W), `n_act` (CNT_W), `out_q`, `tick`, and `running`.
- Reset values: `cnt`=0, `n_act`=DIV_RESET, `out_q`=0, `tick`=0, `running`=0. Therefore `out_clk`=0, `tick`=0, `div_act`=DIV_RESET.
- Sanitise rule: S(v) = 2 if v<2, else v.
- High-phase length H:
  - Even N: H=N/2.
  - Odd N: H=(N+1)/2 by default. With the macro, H=(N−1)/2 (see Configuration).
- Idle (`running`=0):
  - If `en`=0: hold all state.
  - If `en`=1: set `running`=1, `cnt`=0, `n_act`=S(`div_val`), `out_q`=1, `tick`=1.
- Running, `cnt`≠`n_act`−1: `cnt`=`cnt`+1; `out_q`=((`cnt`+1) < H); `tick`=0.
- Running, `cnt`=`n_act`−1 (period boundary):
  - If `en`=1: `cnt`=0, `n_act`=S(`div_val`), `out_q`=1, `tick`=1.
  - If `en`=0: `running`=0, `cnt`=0, `out_q`=0, `tick`=0.
- Ratio changes take effect only at a boundary or at start-up. `div_val` changes mid-period are ignored until then.
- Deasserting `en` mid-period completes the current period in full, then idles with `out_clk` low.
- Counter never wraps past `n_act`−1; `cnt`+1 evaluates at CNT_W+1 bits.
- Async reset mid-period drives `out_clk` low immediately. After release, the block restarts from idle.

## Timing
- Start latency: `en` sampled high at edge k, in idle → `out_clk` and `tick` rise at edge k.
- Period: exactly N `clk` cycles. Default high time H cycles, low time N−H.
- `tick` asserts on edges 0, N, 2N, … of a run, for 1 cycle each.
- N=2 with `en` held high is cycle-identical to the toggle divide-by-2 after its first edge.
- `div_act` updates on the same edge that starts the new period.

## Configuration
- `CLK_DIV_ODD_DUTY50_EN`: when defined, odd N produces exactly 50 % duty.
  - Adds a negedge-`clk` flop `out_n` that samples `out_q`. It is async-cleared by `rst`.
  - Odd N: `out_clk` = `out_q` | `out_n` with H=(N−1)/2, giving (N/2) cycles high and (N/2) cycles low.
  - Even N: `out_n` is masked to 0.
  - `tick` is unchanged.
- When undefined: no negedge logic; `out_clk`=`out_q`; odd-N duty is (N+1)/2 high, (N−1)/2 low.

## Test plan
- Reset: hold `rst`=0 mid-run with N=5 → `out_clk`=0 and `tick`=0 asynchronously, `div_act`=2. Release with `en`=0 → outputs stay 0.
- Even ratio: `div_val`=4, `en`=1 → `out_clk` pattern 1100 repeating; `tick` on every 4th edge; `div_act`=4.
- Odd ratio: `div_val`=5 →
  - Without macro: `out_clk` high 3 cycles, low 2.
  - With macro: high 2.5 cycles, low 2.5.
  - Period is 5 cycles in both builds.
- Ratio change: N=6 running, `div_val`→3 at cycle 2 of a period → the current period still lasts 6 cycles; the next period is 3 cycles; `div_act` changes on that boundary edge.
- Enable gating: drop `en` at cycle 1 of an N=4 period → the period completes, then `out_clk`=0 and no further `tick`. Re-raise `en` → `tick` and `out_clk` rise on the first edge `en` is sampled high.
- Degenerate inputs: `div_val`=0 and `div_val`=1 → N=2 behaviour. `div_val`=255 with CNT_W=8 → 255-cycle period with no counter wrap.

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with tick strobe.
// Define CLK_DIV_ODD_DUTY50_EN for exact 50% duty on odd ratios (adds a negedge stage).
module clk_div_prog #(
    parameter int CNT_W     = 8,
    parameter int DIV_RESET = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    output logic             out_clk,
    output logic             tick,
    output logic [CNT_W-1:0] div_act
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_n_act;
    logic             r_out_q;
    logic             r_tick;
    logic             r_running;
    logic [CNT_W-1:0] w_n_req;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W:0]   w_high;
    logic             w_last;

    assign w_n_req   = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_last    = (w_cnt_inc == {1'b0, r_n_act});
`ifdef CLK_DIV_ODD_DUTY50_EN
    assign w_high    = {1'b0, r_n_act} >> 1;
`else
    assign w_high    = ({1'b0, r_n_act} + (CNT_W+1)'(1)) >> 1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_n_act   <= CNT_W'(DIV_RESET);
            r_out_q   <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else if (!r_running) begin
            if (en) begin
                r_running <= 1'b1;
                r_cnt     <= '0;
                r_n_act   <= w_n_req;
                r_out_q   <= 1'b1;
                r_tick    <= 1'b1;
            end
        end else if (w_last) begin
            // period boundary: the only point where ratio and enable take effect
            r_cnt     <= '0;
            r_out_q   <= en;
            r_tick    <= en;
            r_running <= en;
            if (en) r_n_act <= w_n_req;
        end else begin
            r_cnt   <= w_cnt_inc[CNT_W-1:0];
            r_out_q <= (w_cnt_inc < w_high);
            r_tick  <= 1'b0;
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic r_out_n;
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) r_out_n <= 1'b0;
        else      r_out_n <= r_out_q;
    end
    assign out_clk = r_out_q | (r_out_n & r_n_act[0]);
`else
    assign out_clk = r_out_q;
`endif
    assign tick    = r_tick;
    assign div_act = r_n_act;
endmodule
